// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1/8N2 UART receiver packing four LSB-first bytes into one 32-bit word, with framing and inter-byte timeout errors.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RxD,
  output logic [31:0] dataOut,
  output logic        dataValid,
  output logic [7:0]  byteOut,
  output logic        byteValid,
  output logic        frameErr,
  output logic        timeoutErr,
  output logic        busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int TLIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW   = $clog2(TLIM + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t      state_q, state_d;
  logic [2:0]  sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [7:0]  shift_q, shift_d, byte_q, byte_d;
  logic [23:0] word_q, word_d;
  logic [31:0] data_q, data_d;
  logic        bv_q, bv_d, dv_q, dv_d, fe_q, fe_d, to_q, to_d;
  logic        rxs, prev, tick, start, active, expire;
  // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
  assign rxs    = sync_q[1];
  assign prev   = sync_q[2];
  assign tick   = cnt_q == '0;
  assign start  = state_q == IDLE && prev && !rxs;
  assign active = state_q == IDLE && bcnt_q != '0;
  assign expire = active && tcnt_q == TW'(TLIM - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
    tcnt_d  = (active && !start && !expire) ? tcnt_q + 1'b1 : '0;
    bit_d   = bit_q;
    bcnt_d  = expire ? 2'd0 : bcnt_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    word_d  = word_q;
    data_d  = data_q;
    bv_d    = 1'b0;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    to_d    = expire;
    case (state_q)
      IDLE: if (start) begin
        state_d = START;
        cnt_d   = CW'(HALF - 1);
      end
      START: if (tick) begin
        state_d = rxs ? IDLE : DATA;
        cnt_d   = CW'(CLKS_PER_BIT - 1);
        bit_d   = 3'd0;
      end
      DATA: if (tick) begin
        shift_d[bit_q] = rxs;
        cnt_d          = CW'(CLKS_PER_BIT - 1);
        bit_d          = bit_q + 1'b1;
        state_d        = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        if (rxs) begin
          state_d = IDLE;
          byte_d  = shift_q;
          bv_d    = 1'b1;
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            data_d = {shift_q, word_q};
            dv_d   = 1'b1;
          end else begin
            word_d[{bcnt_q, 3'b000} +: 8] = shift_q;
          end
        end else begin
          state_d = WAIT_HIGH;
          fe_d    = 1'b1;
          bcnt_d  = 2'd0;
        end
      end
      WAIT_HIGH: state_d = rxs ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= 3'b111;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      bit_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      data_q  <= '0;
      bv_q    <= 1'b0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], RxD};
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      data_q  <= data_d;
      bv_q    <= bv_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      to_q    <= to_d;
    end
  end
  assign dataOut    = data_q;
  assign dataValid  = dv_q;
  assign byteOut    = byte_q;
  assign byteValid  = bv_q;
  assign frameErr   = fe_q;
  assign timeoutErr = to_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: directed bench for uart_word_rx at 16 clocks per bit.
module tb_uart_word_rx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        RxD;
  logic [31:0] dataOut;
  logic        dataValid;
  logic [7:0]  byteOut;
  logic        byteValid;
  logic        frameErr;
  logic        timeoutErr;
  logic        busy;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_start = 0, dv_cyc = 0;
  int bv_n = 0, dv_n = 0, fe_n = 0, to_n = 0;
  int bv0, dv0, fe0, to0, wb;
  logic [7:0]  blog[$];
  logic [31:0] wlog[$];
  uart_word_rx #(.CLKS_PER_BIT(16), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .rst_n(rst_n), .RxD(RxD),
    .dataOut(dataOut), .dataValid(dataValid),
    .byteOut(byteOut), .byteValid(byteValid),
    .frameErr(frameErr), .timeoutErr(timeoutErr), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n) begin
    if (byteValid) begin
      bv_n++;
      blog.push_back(byteOut);
    end
    if (dataValid) begin
      dv_n++;
      wlog.push_back(dataOut);
      dv_cyc = cyc;
    end
    if (frameErr) fe_n++;
    if (timeoutErr) to_n++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic bit_time(input logic v);
    RxD = v;
    repeat (16) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] d, input logic stop_v, input int nstop);
    last_start = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(stop_v);
    if (nstop == 2) bit_time(1'b1);
    RxD = 1'b1;
  endtask
  task automatic snap();
    bv0 = bv_n; dv0 = dv_n; fe0 = fe_n; to0 = to_n;
  endtask
  initial begin
    rst_n = 1'b0;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", dataOut, 32'h0);
    chk("rst_misc", {19'd0, byteOut, dataValid, byteValid, frameErr, timeoutErr, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // 8N2 word with latency check on the last byte
    snap();
    send_byte(8'hEF, 1'b1, 2);
    send_byte(8'hBE, 1'b1, 2);
    send_byte(8'hAD, 1'b1, 2);
    send_byte(8'hDE, 1'b1, 2);
    repeat (10) @(negedge clk);
    chk("b0", blog[0], 32'hEF);
    chk("b1", blog[1], 32'hBE);
    chk("b2", blog[2], 32'hAD);
    chk("b3", blog[3], 32'hDE);
    chk("w1_bv", bv_n - bv0, 4);
    chk("w1_dv", dv_n - dv0, 1);
    chk("w1_data", dataOut, 32'hDEADBEEF);
    chk("w1_lat", dv_cyc - last_start, 155);
    // glitch between bytes 1 and 2 must not disturb the partial word
    snap();
    send_byte(8'h55, 1'b1, 1);
    send_byte(8'h66, 1'b1, 1);
    repeat (5) @(negedge clk);
    RxD = 1'b0;
    repeat (3) @(negedge clk);
    RxD = 1'b1;
    chk("gl_busy_hi", busy, 1);
    repeat (12) @(negedge clk);
    chk("gl_busy_lo", busy, 0);
    chk("gl_bv", bv_n - bv0, 2);
    send_byte(8'h77, 1'b1, 1);
    send_byte(8'h88, 1'b1, 1);
    repeat (10) @(negedge clk);
    chk("gl_data", dataOut, 32'h88776655);
    chk("gl_dv", dv_n - dv0, 1);
    // framing error discards the partial word
    snap();
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b1, 1);
    send_byte(8'h33, 1'b0, 1);
    repeat (16) @(negedge clk);
    send_byte(8'h01, 1'b1, 1);
    send_byte(8'h02, 1'b1, 1);
    send_byte(8'h03, 1'b1, 1);
    send_byte(8'h04, 1'b1, 1);
    repeat (10) @(negedge clk);
    chk("fe_cnt", fe_n - fe0, 1);
    chk("fe_dv", dv_n - dv0, 1);
    chk("fe_data", dataOut, 32'h04030201);
    // inter-byte timeout
    snap();
    send_byte(8'h99, 1'b1, 1);
    send_byte(8'h98, 1'b1, 1);
    repeat (340) @(negedge clk);
    chk("to_mid", to_n - to0, 1);
    send_byte(8'hAA, 1'b1, 1);
    send_byte(8'hBB, 1'b1, 1);
    send_byte(8'hCC, 1'b1, 1);
    send_byte(8'hDD, 1'b1, 1);
    repeat (10) @(negedge clk);
    chk("to_cnt", to_n - to0, 1);
    chk("to_dv", dv_n - dv0, 1);
    chk("to_data", dataOut, 32'hDDCCBBAA);
    // asynchronous reset in the middle of byte 2's data bits
    send_byte(8'h10, 1'b1, 1);
    send_byte(8'h20, 1'b1, 1);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_data", dataOut, 32'h0);
    chk("rr_misc", {19'd0, byteOut, dataValid, byteValid, frameErr, timeoutErr, busy}, 32'h0);
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    snap();
    send_byte(8'h78, 1'b1, 1);
    send_byte(8'h56, 1'b1, 1);
    send_byte(8'h34, 1'b1, 1);
    send_byte(8'h12, 1'b1, 1);
    repeat (10) @(negedge clk);
    chk("rr_dv", dv_n - dv0, 1);
    chk("rr_result", dataOut, 32'h12345678);
    // back-to-back words, one stop bit, no idle gap
    snap();
    wb = wlog.size();
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1, 1);
    for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b1, 1);
    repeat (10) @(negedge clk);
    chk("bb_dv", dv_n - dv0, 2);
    chk("bb_fe", fe_n - fe0, 0);
    if (wlog.size() >= wb + 2) begin
      chk("bb_w0", wlog[wb], 32'h00000000);
      chk("bb_w1", wlog[wb + 1], 32'hFFFFFFFF);
    end else begin
      chk("bb_words", wlog.size() - wb, 2);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
